rr_grant_sequencer: RTL and testbench

Round-robin arbiter that shares one decoder-selected resource among four requesters. It drives the address and enable inputs of the 2-to-4 enable decoder (addr0, addr1, enable) so that at most one decoder output is active at a time. It also provides a matching one-hot grant vector. Grants are held until the owner releases or a hold limit expires, and every handover has a break-before-make gap.

---
 rtl/rr_grant_sequencer.sv | 110 +++++++++++
 tb/tb_rr_grant_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter for four requesters that drives a 2-to-4 enable decoder.
// Grants are held until release or a hold limit, with a one-cycle gap between owners.
module rr_grant_sequencer #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       addr0,
  output logic       addr1,
  output logic       enable,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

  state_e           state_q;
  logic [1:0]       owner_q;
  logic [1:0]       last_q;
  logic [CNT_W-1:0] cnt_q;
  logic             enable_q;
  logic [3:0]       gnt_q;
  logic             busy_q;
  logic             timeout_q;

  logic [1:0] win;
  logic       found;
  logic [1:0] idx;

  // Scan from last+1 upward; the last owner itself is checked last.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      owner_q   <= 2'd0;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      enable_q  <= 1'b0;
      gnt_q     <= 4'b0000;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle, StGap: begin
          if (found) begin
            state_q  <= StGrant;
            owner_q  <= win;
            cnt_q    <= '0;
            enable_q <= 1'b1;
            gnt_q    <= 4'b0001 << win;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= StIdle;
            enable_q <= 1'b0;
            gnt_q    <= 4'b0000;
            busy_q   <= 1'b0;
          end
        end
        StGrant: begin
          if (!req[owner_q]) begin
            state_q  <= StGap;
            last_q   <= owner_q;
            enable_q <= 1'b0;
            gnt_q    <= 4'b0000;
          end else if (MAX_HOLD != 0 && cnt_q == HoldLast) begin
            state_q   <= StGap;
            last_q    <= owner_q;
            enable_q  <= 1'b0;
            gnt_q     <= 4'b0000;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          enable_q <= 1'b0;
          gnt_q    <= 4'b0000;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign addr0   = owner_q[0];
  assign addr1   = owner_q[1];
  assign enable  = enable_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed bench for rr_grant_sequencer: one instance with MAX_HOLD=4, one with the limit disabled.
module tb_rr_grant_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] req0;
  logic       a0, a1, en, bsy, to;
  logic [3:0] g;
  logic       b0_a0, b0_a1, b0_en, b0_bsy, b0_to;
  logic [3:0] b0_g;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_grant_sequencer #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr0(a0), .addr1(a1),
    .enable(en), .gnt(g), .busy(bsy), .timeout(to)
  );

  rr_grant_sequencer #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .addr0(b0_a0), .addr1(b0_a1),
    .enable(b0_en), .gnt(b0_g), .busy(b0_bsy), .timeout(b0_to)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output bundle of the MAX_HOLD=4 instance.
  task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] ea,
                           input logic ee, input logic eb, input logic et);
    check({tag, ".gnt"}, 32'(g), 32'(eg));
    check({tag, ".addr"}, 32'({a1, a0}), 32'(ea));
    check({tag, ".enable"}, 32'(en), 32'(ee));
    check({tag, ".busy"}, 32'(bsy), 32'(eb));
    check({tag, ".timeout"}, 32'(to), 32'(et));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    req0  = 4'b0000;
    #1;
    // 1: reset state with all requests pending
    check_out("rst", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_out("rst_clk", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    tick();
    check_out("t1_grant0", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    check_out("t1_gap", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("t1_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // 2: single requester 2 for three sampled cycles
    req = 4'b0100;
    tick();
    check_out("t2_g1", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    tick();
    check_out("t2_g2", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    tick();
    check_out("t2_g3", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    check_out("t2_gap", 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("t2_idle", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);

    // 3: all request continuously; hold limit rotates 0,1,2,3,0
    #3 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        check_out($sformatf("t3_own%0d_c%0d", k, c), 4'b0001 << (k % 4), 2'(k % 4),
                  1'b1, 1'b1, 1'b0);
      end
      tick();
      check_out($sformatf("t3_gap%0d", k), 4'b0000, 2'(k % 4), 1'b0, 1'b1, 1'b1);
    end
    req = 4'b0000;
    tick();
    check_out("t3_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // 4: after owner 1 releases, 3 beats 0
    req = 4'b0010;
    tick();
    check_out("t4_own1", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
    req = 4'b1001;
    tick();
    check_out("t4_gap1", 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("t4_own3", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
    req = 4'b0001;
    tick();
    check_out("t4_gap3", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("t4_own0", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    tick();
    check_out("t4_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // 5: asynchronous reset in the middle of a grant to requester 2
    req = 4'b0100;
    tick();
    check_out("t5_own2", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check_out("t5_async", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    req = 4'b0101;
    #2 rst_n = 1'b1;
    tick();
    check_out("t5_own0", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    tick();

    // 6: hold limit disabled, requester 1 holds for 40 cycles
    req0 = 4'b0010;
    for (int i = 0; i < 40; i++) begin
      tick();
      check($sformatf("t6_gnt%0d", i), 32'(b0_g), 32'h2);
      check($sformatf("t6_to%0d", i), 32'(b0_to), 32'h0);
    end
    check("t6_addr", 32'({b0_a1, b0_a0}), 32'h1);
    check("t6_en", 32'(b0_en), 32'h1);
    req0 = 4'b0000;
    tick();
    check("t6_gap_en", 32'(b0_en), 32'h0);
    check("t6_gap_busy", 32'(b0_bsy), 32'h1);
    check("t6_gap_to", 32'(b0_to), 32'h0);
    tick();
    check("t6_idle_busy", 32'(b0_bsy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
